stack_upstream_tx: RTL and testbench
====================================

Name: stack_upstream_tx

Overview:
- Transmit end of the Stack Bus upstream interface: the block that drives stu__mgr__valid/cntl/type/data/oob_data into one manager and obeys mgr__stu__ready.
- Collects result words from NUM_SRC producer lanes (PE result ports, one lane per PE) and frames each lane's burst as one upstream message.
- Arbitrates between lanes round-robin and holds the grant for a whole message.
- Sits in the stack-side logic, one instance per manager, between the PE array result ports and the manager.

Parameters:
NUM_SRC, 4, number of producer lanes (2..16)
SRC_ID_W, 2, lane index width = clog2(NUM_SRC)
DATA_W, 64, upstream data width (STACK_UP_INTF_DATA_RANGE)
TYPE_W, 2, type field width (STACK_UP_INTF_TYPE_RANGE)
OOB_W, 8, oob data width (STACK_UP_INTF_OOB_DATA_RANGE); must be >= SRC_ID_W
MAX_PKT_LEN, 64, maximum words per message before forced termination
LEN_W, 7, counter width = clog2(MAX_PKT_LEN+1)

Ports:
clk  in  1  system clock, all logic rising-edge
reset_poweron  in  1  asynchronous, active-high reset
src__stu__valid  in  NUM_SRC  per-lane word valid
src__stu__last  in  NUM_SRC  per-lane final word of burst
src__stu__type  in  NUM_SRC*TYPE_W  per-lane type, lane i at [i*TYPE_W +: TYPE_W]
src__stu__data  in  NUM_SRC*DATA_W  per-lane data, lane i at [i*DATA_W +: DATA_W]
stu__src__ready  out  NUM_SRC  per-lane accept
stu__mgr__valid  out  1  upstream word valid
stu__mgr__cntl  out  2  framing: 2'b01 SOM, 2'b00 MOM, 2'b10 EOM, 2'b11 SOM_EOM
stu__mgr__type  out  TYPE_W  type of word
stu__mgr__data  out  DATA_W  data word
stu__mgr__oob_data  out  OOB_W  zero-extended source lane id
mgr__stu__ready  in  1  manager accepts the word when valid & ready
stu__sys__pkt_count  out  16  messages completed, wraps at 0xFFFF->0
stu__sys__overrun  out  1  sticky, set on forced termination

Behaviour:
- Reset (async assert): FSM=IDLE, rr_ptr=0, word count=0, stu__mgr__valid=0, cntl/type/data/oob=0, stu__src__ready=0, pkt_count=0, overrun=0. Releasing reset mid-message abandons the message; no EOM is emitted for it.
- Output stage: one register stage.
  - Load when out_empty = !stu__mgr__valid | mgr__stu__ready.
  - While valid & !ready, all stu__mgr__* outputs hold stable.
  - Source-to-output latency is one cycle.
- FSM IDLE:
  - If any src__stu__valid is set, grant the first requesting lane searching from rr_ptr upward with wrap. Latch grant and count=0, then go to XFER.
  - This costs one arbitration cycle; no word is accepted in IDLE.
- FSM XFER:
  - stu__src__ready[grant] = out_empty. All other ready bits are 0.
  - Word accepted when src valid & ready: load the output regs with that lane's type/data, oob=grant, and count++.
  - cntl is SOM if count==0 and !last; SOM_EOM if count==0 and last; EOM if last; otherwise MOM.
  - On an accepted last: go to IDLE, rr_ptr=grant+1 (wrap at NUM_SRC), pkt_count++.
- Forced termination: if an accepted word without last makes count==MAX_PKT_LEN:
  - cntl is EOM (SOM_EOM if MAX_PKT_LEN==1), overrun is set, pkt_count++, go to IDLE, rr_ptr advances.
  - The lane's remaining words form a new message after re-arbitration.
- Simultaneous events:
  - A new lane's request during XFER waits; the grant never changes mid-message.
  - A granted lane dropping valid mid-message inserts bubbles; the grant holds.
  - The output register may be loaded in the same cycle it is drained.
- Only the granted lane's ready may be high; data of non-granted lanes is ignored.

Test Plan:
- Single lane: lane 2 sends one word (last=1, data=0xA5, type=1) -> next cycle valid=1, cntl=2'b11, data=0xA5, type=1, oob=2; pkt_count=1.
- Round-robin: lanes 0 and 3 each send 3-word bursts starting in the same cycle, mgr ready=1.
  - Output is lane 0 as SOM, MOM, EOM, then one idle cycle, then lane 3 as SOM, MOM, EOM.
  - A repeat with both lanes requesting grants lane 3 first? No: rr_ptr=0 after lane 3 wraps to 0, so lane 0 is granted first.
- Backpressure: hold mgr__stu__ready=0 for 5 cycles during a 4-word burst.
  - Output stays stable while stalled; stu__src__ready[grant]=0 during the stall.
  - No word is lost or duplicated; data order is preserved.
- Overrun: MAX_PKT_LEN=4, lane 1 sends 6 words with last only on word 6.
  - Output is SOM, MOM, MOM, EOM, then SOM, EOM; overrun=1; pkt_count=2.
- Reset mid-message: assert reset_poweron after 2 of 5 words.
  - Outputs clear asynchronously: valid=0, pkt_count=0, overrun=0.
  - After release, a fresh 1-word message from lane 0 emits SOM_EOM.
- Bubble tolerance: granted lane drops valid for 3 cycles mid-burst while lane 1 requests.
  - The grant holds; lane 1 is served only after the EOM.

Source files
------------

// File: rtl/stack_upstream_tx.sv
// Stack Bus upstream transmitter: round-robin lane arbiter, message framer
// and a single registered output stage toward one manager.

module stack_upstream_tx_lane #(
    parameter int TYPE_W = 2,
    parameter int DATA_W = 64
) (
    input  logic              valid,
    input  logic              last,
    input  logic [TYPE_W-1:0] src_type,
    input  logic [DATA_W-1:0] src_data,
    input  logic              sel,
    input  logic              out_empty,
    output logic              req,
    output logic              ready,
    output logic              valid_g,
    output logic              last_g,
    output logic [TYPE_W-1:0] type_g,
    output logic [DATA_W-1:0] data_g
);
    // Gated outputs are zero unless this lane owns the grant, so the top can OR-merge them.
    assign req     = valid;
    assign ready   = sel & out_empty;
    assign valid_g = sel & valid;
    assign last_g  = sel & last;
    assign type_g  = sel ? src_type : '0;
    assign data_g  = sel ? src_data : '0;
endmodule

module stack_upstream_tx #(
    parameter int NUM_SRC     = 4,
    parameter int SRC_ID_W    = 2,
    parameter int DATA_W      = 64,
    parameter int TYPE_W      = 2,
    parameter int OOB_W       = 8,
    parameter int MAX_PKT_LEN = 64,
    parameter int LEN_W       = 7
) (
    input  logic                      clk,
    input  logic                      reset_poweron,
    input  logic [NUM_SRC-1:0]        src__stu__valid,
    input  logic [NUM_SRC-1:0]        src__stu__last,
    input  logic [NUM_SRC*TYPE_W-1:0] src__stu__type,
    input  logic [NUM_SRC*DATA_W-1:0] src__stu__data,
    output logic [NUM_SRC-1:0]        stu__src__ready,
    output logic                      stu__mgr__valid,
    output logic [1:0]                stu__mgr__cntl,
    output logic [TYPE_W-1:0]         stu__mgr__type,
    output logic [DATA_W-1:0]         stu__mgr__data,
    output logic [OOB_W-1:0]          stu__mgr__oob_data,
    input  logic                      mgr__stu__ready,
    output logic [15:0]               stu__sys__pkt_count,
    output logic                      stu__sys__overrun
);
    localparam logic [1:0] CNTL_MOM     = 2'b00;
    localparam logic [1:0] CNTL_SOM     = 2'b01;
    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

    typedef enum logic {IDLE, XFER} state_t;

    typedef struct packed {
        logic              vld;
        logic [1:0]        cntl;
        logic [TYPE_W-1:0] typ;
        logic [DATA_W-1:0] data;
        logic [OOB_W-1:0]  oob;
    } up_word_t;

    state_t                           state_q, state_d;
    logic [SRC_ID_W-1:0]              grant_q, rr_ptr_q, arb_lane, rr_next;
    logic                             arb_found;
    logic [LEN_W-1:0]                 count_q, count_inc;
    up_word_t                         out_q, out_d;
    logic                             out_empty;
    logic                             accept, force_end, msg_end, end_word;
    logic [15:0]                      pkt_count_q;
    logic                             overrun_q;

    logic [NUM_SRC-1:0]               lane_req, lane_sel, lane_vld_g, lane_last_g;
    logic [NUM_SRC-1:0][TYPE_W-1:0]   lane_type_g;
    logic [NUM_SRC-1:0][DATA_W-1:0]   lane_data_g;
    logic                             g_valid, g_last;
    logic [TYPE_W-1:0]                g_type;
    logic [DATA_W-1:0]                g_data;

    assign out_empty = !out_q.vld | mgr__stu__ready;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        assign lane_sel[i] = (state_q == XFER) && (grant_q == SRC_ID_W'(i));

        stack_upstream_tx_lane #(
            .TYPE_W (TYPE_W),
            .DATA_W (DATA_W)
        ) u_lane (
            .valid     (src__stu__valid[i]),
            .last      (src__stu__last[i]),
            .src_type  (src__stu__type[i*TYPE_W +: TYPE_W]),
            .src_data  (src__stu__data[i*DATA_W +: DATA_W]),
            .sel       (lane_sel[i]),
            .out_empty (out_empty),
            .req       (lane_req[i]),
            .ready     (stu__src__ready[i]),
            .valid_g   (lane_vld_g[i]),
            .last_g    (lane_last_g[i]),
            .type_g    (lane_type_g[i]),
            .data_g    (lane_data_g[i])
        );
    end

    always_comb begin
        g_type = '0;
        g_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            g_type = g_type | lane_type_g[i];
            g_data = g_data | lane_data_g[i];
        end
        g_valid = |lane_vld_g;
        g_last  = |lane_last_g;
    end

    // First requester at or above rr_ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_lane  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!arb_found && lane_req[(int'(rr_ptr_q) + k) % NUM_SRC]) begin
                arb_found = 1'b1;
                arb_lane  = SRC_ID_W'((int'(rr_ptr_q) + k) % NUM_SRC);
            end
        end
    end

    assign rr_next = (grant_q == SRC_ID_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) state_q <= IDLE;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        accept    = 1'b0;
        force_end = 1'b0;
        msg_end   = 1'b0;
        end_word  = 1'b0;
        count_inc = count_q + 1'b1;
        if (out_empty) out_d.vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_found) state_d = XFER;
            end
            XFER: begin
                accept    = g_valid & out_empty;
                force_end = accept && !g_last && (count_inc == LEN_W'(MAX_PKT_LEN));
                end_word  = g_last | force_end;
                msg_end   = accept & end_word;
                if (accept) begin
                    out_d.vld  = 1'b1;
                    out_d.typ  = g_type;
                    out_d.data = g_data;
                    out_d.oob  = OOB_W'(grant_q);
                    if (count_q == '0) out_d.cntl = end_word ? CNTL_SOM_EOM : CNTL_SOM;
                    else               out_d.cntl = end_word ? CNTL_EOM : CNTL_MOM;
                end
                if (msg_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            out_q       <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            count_q     <= '0;
            pkt_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            out_q <= out_d;
            if (state_q == IDLE && arb_found) begin
                grant_q <= arb_lane;
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_inc;
            end
            if (msg_end) begin
                rr_ptr_q    <= rr_next;
                pkt_count_q <= pkt_count_q + 16'd1;
            end
            if (force_end) overrun_q <= 1'b1;
        end
    end

    assign stu__mgr__valid     = out_q.vld;
    assign stu__mgr__cntl      = out_q.cntl;
    assign stu__mgr__type      = out_q.typ;
    assign stu__mgr__data      = out_q.data;
    assign stu__mgr__oob_data  = out_q.oob;
    assign stu__sys__pkt_count = pkt_count_q;
    assign stu__sys__overrun   = overrun_q;
endmodule

// File: tb/tb_stack_upstream_tx.sv
// Directed bench for stack_upstream_tx: vector table of single-word messages
// plus hand sequences for round-robin, stall, overrun, reset and bubbles.

module tb_stack_upstream_tx;
    localparam int NS = 4, IDW = 2, DW = 64, TW = 2, OW = 8, MPL = 4, LW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     s_valid, s_last, s_ready;
    logic [NS*TW-1:0]  s_type;
    logic [NS*DW-1:0]  s_data;
    logic              m_valid, m_ready, ovr;
    logic [1:0]        m_cntl;
    logic [TW-1:0]     m_type;
    logic [DW-1:0]     m_data;
    logic [OW-1:0]     m_oob;
    logic [15:0]       pkt;

    always #5 clk = ~clk;

    stack_upstream_tx #(
        .NUM_SRC(NS), .SRC_ID_W(IDW), .DATA_W(DW), .TYPE_W(TW),
        .OOB_W(OW), .MAX_PKT_LEN(MPL), .LEN_W(LW)
    ) dut (
        .clk(clk), .reset_poweron(rst),
        .src__stu__valid(s_valid), .src__stu__last(s_last),
        .src__stu__type(s_type), .src__stu__data(s_data),
        .stu__src__ready(s_ready),
        .stu__mgr__valid(m_valid), .stu__mgr__cntl(m_cntl),
        .stu__mgr__type(m_type), .stu__mgr__data(m_data),
        .stu__mgr__oob_data(m_oob), .mgr__stu__ready(m_ready),
        .stu__sys__pkt_count(pkt), .stu__sys__overrun(ovr)
    );

    // per-lane source queues
    logic [DW-1:0] q_data [NS][16];
    logic [TW-1:0] q_type [NS][16];
    logic          q_last [NS][16];
    int            q_gap  [NS][16];
    int            q_len [NS], q_idx [NS], q_pause [NS], fire_cyc [NS];

    // words accepted by the manager
    logic [DW-1:0] c_data [64];
    logic [1:0]    c_cntl [64];
    logic [OW-1:0] c_oob  [64];
    logic [TW-1:0] c_type [64];
    int            c_cyc  [64];
    int            c_n, cyc;
    int            passed = 0, total = 0;

    typedef struct {
        int          lane;
        logic [63:0] data;
        logic [1:0]  typ;
        logic [1:0]  exp_cntl;
        logic [7:0]  exp_oob;
        logic [15:0] exp_pkt;
    } vec_t;
    vec_t vt [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic drive();
        for (int l = 0; l < NS; l++) begin
            if (q_idx[l] < q_len[l] && q_pause[l] == 0) begin
                s_valid[l]            = 1'b1;
                s_last[l]             = q_last[l][q_idx[l]];
                s_type[l*TW +: TW]    = q_type[l][q_idx[l]];
                s_data[l*DW +: DW]    = q_data[l][q_idx[l]];
            end else begin
                s_valid[l]            = 1'b0;
                s_last[l]             = 1'b0;
                s_type[l*TW +: TW]    = '0;
                s_data[l*DW +: DW]    = '0;
            end
        end
    endtask

    task automatic tick();
        logic [NS-1:0] fired;
        cyc++;
        drive();
        @(negedge clk);
        fired = s_valid & s_ready;
        for (int l = 0; l < NS; l++) if (fired[l]) fire_cyc[l] = cyc;
        if (m_valid && m_ready && c_n < 64) begin
            c_data[c_n] = m_data; c_cntl[c_n] = m_cntl;
            c_oob[c_n]  = m_oob;  c_type[c_n] = m_type;
            c_cyc[c_n]  = cyc;    c_n++;
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < NS; l++) begin
            if (q_pause[l] > 0) q_pause[l]--;
            if (fired[l]) begin
                q_idx[l]++;
                if (q_idx[l] < q_len[l]) q_pause[l] = q_gap[l][q_idx[l]];
            end
        end
    endtask

    task automatic set_burst(input int l, input int n, input logic [63:0] base, input logic [1:0] typ);
        for (int i = 0; i < n; i++) begin
            q_data[l][i] = base + 64'(i);
            q_type[l][i] = typ;
            q_last[l][i] = (i == n - 1);
            q_gap[l][i]  = 0;
        end
        q_len[l] = n; q_idx[l] = 0; q_pause[l] = 0;
    endtask

    task automatic clear_q();
        for (int l = 0; l < NS; l++) begin
            q_len[l] = 0; q_idx[l] = 0; q_pause[l] = 0; fire_cyc[l] = 0;
        end
    endtask

    task automatic run_until(input string nm, input int n, input int budget);
        int b = 0;
        while (c_n < n && b < budget) begin
            tick();
            b++;
        end
        chk({nm, "_count"}, 64'(c_n), 64'(n));
    endtask

    task automatic chk_word(input string nm, input int i, input logic [1:0] cntl,
                            input logic [7:0] oob, input logic [63:0] data);
        chk({nm, "_cntl"}, 64'(c_cntl[i]), 64'(cntl));
        chk({nm, "_oob"},  64'(c_oob[i]),  64'(oob));
        chk({nm, "_data"}, c_data[i], data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_q();
        drive();
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        c_n = 0;
    endtask

    initial begin
        vt[0] = '{2, 64'hA5, 2'd1, 2'b11, 8'd2, 16'd1};
        vt[1] = '{0, 64'h1111_2222_3333_4444, 2'd2, 2'b11, 8'd0, 16'd2};
        vt[2] = '{3, 64'hFFFF_0000_FFFF_0000, 2'd3, 2'b11, 8'd3, 16'd3};
        vt[3] = '{1, 64'h0, 2'd0, 2'b11, 8'd1, 16'd4};

        cyc = 0; c_n = 0;
        rst = 1'b1; m_ready = 1'b1;
        clear_q(); drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_cntl",  64'(m_cntl),  64'd0);
        chk("rst_data",  m_data,       64'd0);
        chk("rst_oob",   64'(m_oob),   64'd0);
        chk("rst_ready", 64'(s_ready), 64'd0);
        chk("rst_pkt",   64'(pkt),     64'd0);
        chk("rst_ovr",   64'(ovr),     64'd0);
        rst = 1'b0;

        // single-word messages from each lane
        for (int i = 0; i < 4; i++) begin
            c_n = 0;
            set_burst(vt[i].lane, 1, vt[i].data, vt[i].typ);
            run_until($sformatf("vec%0d", i), 1, 20);
            chk($sformatf("vec%0d_cntl", i), 64'(c_cntl[0]), 64'(vt[i].exp_cntl));
            chk($sformatf("vec%0d_data", i), c_data[0], vt[i].data);
            chk($sformatf("vec%0d_type", i), 64'(c_type[0]), 64'(vt[i].typ));
            chk($sformatf("vec%0d_oob", i),  64'(c_oob[0]),  64'(vt[i].exp_oob));
            chk($sformatf("vec%0d_pkt", i),  64'(pkt),       64'(vt[i].exp_pkt));
            chk($sformatf("vec%0d_lat", i),  64'(c_cyc[0] - fire_cyc[vt[i].lane]), 64'd1);
        end

        // round-robin, twice
        do_reset();
        for (int r = 0; r < 2; r++) begin
            c_n = 0;
            set_burst(0, 3, 64'h100, 2'd0);
            set_burst(3, 3, 64'h300, 2'd2);
            run_until($sformatf("rr%0d", r), 6, 40);
            chk_word($sformatf("rr%0d_w0", r), 0, 2'b01, 8'd0, 64'h100);
            chk_word($sformatf("rr%0d_w1", r), 1, 2'b00, 8'd0, 64'h101);
            chk_word($sformatf("rr%0d_w2", r), 2, 2'b10, 8'd0, 64'h102);
            chk_word($sformatf("rr%0d_w3", r), 3, 2'b01, 8'd3, 64'h300);
            chk_word($sformatf("rr%0d_w4", r), 4, 2'b00, 8'd3, 64'h301);
            chk_word($sformatf("rr%0d_w5", r), 5, 2'b10, 8'd3, 64'h302);
            chk($sformatf("rr%0d_gap", r), 64'(c_cyc[3] - c_cyc[2]), 64'd2);
        end
        repeat (3) tick();
        chk("rr_no_extra", 64'(c_n), 64'd6);

        // backpressure during a 4-word burst on lane 2
        c_n = 0;
        set_burst(2, 4, 64'h200, 2'd1);
        repeat (3) tick();
        m_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk($sformatf("bp_valid%0d", s), 64'(m_valid), 64'd1);
            chk($sformatf("bp_data%0d", s),  m_data, 64'h201);
            chk($sformatf("bp_cntl%0d", s),  64'(m_cntl), 64'd0);
            chk($sformatf("bp_rdy%0d", s),   64'(s_ready[2]), 64'd0);
        end
        chk("bp_stall_cnt", 64'(c_n), 64'd1);
        m_ready = 1'b1;
        run_until("bp", 4, 20);
        chk_word("bp_w0", 0, 2'b01, 8'd2, 64'h200);
        chk_word("bp_w1", 1, 2'b00, 8'd2, 64'h201);
        chk_word("bp_w2", 2, 2'b00, 8'd2, 64'h202);
        chk_word("bp_w3", 3, 2'b10, 8'd2, 64'h203);
        repeat (2) tick();
        chk("bp_no_dup", 64'(c_n), 64'd4);

        // forced termination at MAX_PKT_LEN
        do_reset();
        chk("ovr_before", 64'(ovr), 64'd0);
        set_burst(1, 6, 64'h500, 2'd3);
        run_until("ovr", 6, 40);
        chk_word("ovr_w0", 0, 2'b01, 8'd1, 64'h500);
        chk_word("ovr_w1", 1, 2'b00, 8'd1, 64'h501);
        chk_word("ovr_w2", 2, 2'b00, 8'd1, 64'h502);
        chk_word("ovr_w3", 3, 2'b10, 8'd1, 64'h503);
        chk_word("ovr_w4", 4, 2'b01, 8'd1, 64'h504);
        chk_word("ovr_w5", 5, 2'b10, 8'd1, 64'h505);
        chk("ovr_flag", 64'(ovr), 64'd1);
        chk("ovr_pkt",  64'(pkt), 64'd2);

        // reset in the middle of a message
        c_n = 0;
        set_burst(0, 5, 64'h700, 2'd0);
        begin
            int b = 0;
            while (q_idx[0] < 2 && b < 20) begin tick(); b++; end
        end
        chk("mid_accepted", 64'(q_idx[0]), 64'd2);
        rst = 1'b1;
        #1;
        chk("mid_valid", 64'(m_valid), 64'd0);
        chk("mid_pkt",   64'(pkt),     64'd0);
        chk("mid_ovr",   64'(ovr),     64'd0);
        chk("mid_ready", 64'(s_ready), 64'd0);
        clear_q(); drive();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        c_n = 0;
        set_burst(0, 1, 64'h7FF, 2'd1);
        run_until("mid_after", 1, 20);
        chk_word("mid_after", 0, 2'b11, 8'd0, 64'h7FF);
        chk("mid_after_pkt", 64'(pkt), 64'd1);

        // granted lane pauses mid-burst while lane 1 requests
        c_n = 0;
        set_burst(0, 3, 64'h800, 2'd0);
        q_gap[0][1] = 3;
        set_burst(1, 1, 64'h900, 2'd2);
        q_pause[1] = 2;
        repeat (2) tick();
        chk("bub_first", 64'(q_idx[0]), 64'd1);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("bub_rdy1_%0d", s), 64'(s_ready[1]), 64'd0);
        end
        run_until("bub", 4, 30);
        chk_word("bub_w0", 0, 2'b01, 8'd0, 64'h800);
        chk_word("bub_w1", 1, 2'b00, 8'd0, 64'h801);
        chk_word("bub_w2", 2, 2'b10, 8'd0, 64'h802);
        chk_word("bub_w3", 3, 2'b11, 8'd1, 64'h900);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
